// File: rtl/split_pkg.sv
// rtl/split_pkg.sv - shared types and constants for the split_eval range evaluator
package split_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic MODE_AND = 1'b0;
    localparam logic MODE_OR  = 1'b1;

    // Every bit of a reset lower bound is 0, every bit of a reset upper bound is 1.
    localparam logic DEF_LO_BIT = 1'b0;
    localparam logic DEF_HI_BIT = 1'b1;

endpackage

// File: rtl/split_range_cmp.sv
// rtl/split_range_cmp.sv - unsigned inclusive range check of one variable
module split_range_cmp #(
    parameter int VAR_W = 16
) (
    input  logic [VAR_W-1:0] v,
    input  logic [VAR_W-1:0] lo,
    input  logic [VAR_W-1:0] hi,
    output logic             pass
);

    // lo > hi can never satisfy both sides, so an inverted range fails naturally.
    assign pass = (lo <= v) && (v <= hi);

endmodule

// File: rtl/split_eval.sv
// rtl/split_eval.sv - sequential AND/OR range evaluator over N_VARS variables
module split_eval
    import split_pkg::*;
#(
    parameter int N_VARS = 35,
    parameter int VAR_W  = 16,
    parameter int IDX_W  = (N_VARS > 1) ? $clog2(N_VARS) : 1,
    parameter int CNT_W  = $clog2(N_VARS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_VARS*VAR_W-1:0] in_vars,
    input  logic                    in_mode,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [VAR_W-1:0]        cfg_lo,
    input  logic [VAR_W-1:0]        cfg_hi,
    output logic                    cfg_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    x,
    output logic [IDX_W-1:0]        dec_idx,
    output logic [CNT_W-1:0]        pass_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VARS - 1);
    localparam logic [IDX_W:0]   N_LIM    = (IDX_W + 1)'(N_VARS);

    state_t state_q;
    state_t state_d;

    logic [VAR_W-1:0] lo_q   [N_VARS];
    logic [VAR_W-1:0] hi_q   [N_VARS];
    logic [VAR_W-1:0] vars_q [N_VARS];
    logic             mode_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] pass_cnt_q;
    logic             x_q;
    logic [IDX_W-1:0] dec_idx_q;

    logic             pass_w;
    logic             is_last;
    logic             decide;
    logic             accept;
    logic             cfg_take;

    assign accept   = (state_q == S_IDLE) && in_valid;
    assign cfg_take = (state_q == S_IDLE) && cfg_we && ({1'b0, cfg_idx} < N_LIM);
    assign is_last  = (idx_q == LAST_IDX);

    // AND stops on the first fail, OR on the first pass; either stops after the last variable.
    assign decide = (mode_q == MODE_AND) ? (!pass_w || is_last) : (pass_w || is_last);

    split_range_cmp #(
        .VAR_W (VAR_W)
    ) u_cmp (
        .v    (vars_q[idx_q]),
        .lo   (lo_q[idx_q]),
        .hi   (hi_q[idx_q]),
        .pass (pass_w)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign cfg_busy  = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign x         = x_q;
    assign dec_idx   = dec_idx_q;
    assign pass_cnt  = pass_cnt_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, scan in EVAL, hold the result in DONE until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_EVAL;
            S_EVAL:  if (decide)    state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Range register file; writes only land while idle, including the accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_VARS; i++) begin
                lo_q[i] <= {VAR_W{DEF_LO_BIT}};
                hi_q[i] <= {VAR_W{DEF_HI_BIT}};
            end
        end else if (cfg_take) begin
            lo_q[cfg_idx] <= cfg_lo;
            hi_q[cfg_idx] <= cfg_hi;
        end
    end

    // Capture the vector on accept, then step one variable per cycle and latch the verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_VARS; i++) begin
                vars_q[i] <= '0;
            end
            mode_q     <= MODE_AND;
            idx_q      <= '0;
            pass_cnt_q <= '0;
            x_q        <= 1'b0;
            dec_idx_q  <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_VARS; i++) begin
                vars_q[i] <= in_vars[i*VAR_W +: VAR_W];
            end
            mode_q     <= in_mode;
            idx_q      <= '0;
            pass_cnt_q <= '0;
            x_q        <= 1'b0;
            dec_idx_q  <= '0;
        end else if (state_q == S_EVAL) begin
            pass_cnt_q <= pass_cnt_q + CNT_W'(pass_w);
            if (decide) begin
                // The deciding variable's own result is the verdict in both modes.
                x_q       <= pass_w;
                dec_idx_q <= idx_q;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_split_eval.sv
// tb/tb_split_eval.sv - randomized self-checking bench for split_eval
module tb_split_eval;

    localparam int NV = 35;
    localparam int VW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NV*VW-1:0] in_vars = '0;
    logic             in_mode = 1'b0;
    logic             cfg_we = 1'b0;
    logic [5:0]       cfg_idx = '0;
    logic [VW-1:0]    cfg_lo = '0;
    logic [VW-1:0]    cfg_hi = '0;
    logic             cfg_busy;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             x;
    logic [5:0]       dec_idx;
    logic [5:0]       pass_cnt;

    int total = 0;
    int bad = 0;

    logic [VW-1:0] lo_m [NV];
    logic [VW-1:0] hi_m [NV];
    logic [VW-1:0] vm   [NV];

    int  e_x, e_dec, e_cnt, e_lat;
    logic g_x;
    int  g_dec, g_cnt, g_lat;

    split_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vars   (in_vars),
        .in_mode   (in_mode),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_lo    (cfg_lo),
        .cfg_hi    (cfg_hi),
        .cfg_busy  (cfg_busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .dec_idx   (dec_idx),
        .pass_cnt  (pass_cnt)
    );

    always #5 clk = ~clk;

    // Reference: walk the variables in order, stop at the first deciding one.
    task automatic model(input int mode);
        int cnt;
        bit p;
        cnt = 0;
        e_x = (mode == 0) ? 1 : 0;
        e_dec = NV - 1;
        for (int i = 0; i < NV; i++) begin
            p = (lo_m[i] <= vm[i]) && (vm[i] <= hi_m[i]);
            if (p) cnt++;
            if ((mode == 0 && !p) || (mode == 1 && p)) begin
                e_x = p;
                e_dec = i;
                break;
            end
        end
        e_cnt = cnt;
        e_lat = e_dec + 2;
    endtask

    task automatic model_reset_ranges();
        for (int i = 0; i < NV; i++) begin
            lo_m[i] = '0;
            hi_m[i] = '1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset_ranges();
    endtask

    task automatic cfg_write(input int idx, input int lo, input int hi);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = 6'(idx);
        cfg_lo  = VW'(lo);
        cfg_hi  = VW'(hi);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (idx < NV) begin
            lo_m[idx] = VW'(lo);
            hi_m[idx] = VW'(hi);
        end
    endtask

    // Drives vm[] in with an optional same-cycle config write; observes verdict and latency.
    task automatic run_vec(input int mode, input bit do_cfg, input int cidx, input int clo, input int chi);
        int m;
        @(negedge clk);
        for (int i = 0; i < NV; i++) in_vars[i*VW +: VW] = vm[i];
        in_mode  = mode[0];
        in_valid = 1'b1;
        if (do_cfg) begin
            cfg_we  = 1'b1;
            cfg_idx = 6'(cidx);
            cfg_lo  = VW'(clo);
            cfg_hi  = VW'(chi);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        m = 1;
        while (!out_valid && m < 200) begin
            @(posedge clk);
            m++;
            @(negedge clk);
        end
        g_lat = out_valid ? m : -1;
        g_x   = x;
        g_dec = int'(dec_idx);
        g_cnt = int'(pass_cnt);
    endtask

    task automatic test_reset();
        total += 6;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (cfg_busy !== 1'b0)  begin bad++; $display("FAIL reset_cfg_busy got=%b want=0", cfg_busy); end
        if (x !== 1'b0)         begin bad++; $display("FAIL reset_x got=%b want=0", x); end
        if (dec_idx !== 6'd0)   begin bad++; $display("FAIL reset_dec_idx got=%0d want=0", dec_idx); end
        if (pass_cnt !== 6'd0)  begin bad++; $display("FAIL reset_pass_cnt got=%0d want=0", pass_cnt); end
    endtask

    task automatic test_full_scan();
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom);
        run_vec(0, 0, 0, 0, 0);
        total += 4;
        if (g_x !== 1'b1) begin bad++; $display("FAIL full_x got=%b want=1", g_x); end
        if (g_dec != 34)  begin bad++; $display("FAIL full_dec got=%0d want=34", g_dec); end
        if (g_cnt != 35)  begin bad++; $display("FAIL full_cnt got=%0d want=35", g_cnt); end
        if (g_lat != 36)  begin bad++; $display("FAIL full_lat got=%0d want=36", g_lat); end
    endtask

    task automatic test_and_fail();
        cfg_write(3, 10, 20);
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom);
        vm[3] = 16'd25;
        run_vec(0, 0, 0, 0, 0);
        total += 4;
        if (g_x !== 1'b0) begin bad++; $display("FAIL andf_x got=%b want=0", g_x); end
        if (g_dec != 3)   begin bad++; $display("FAIL andf_dec got=%0d want=3", g_dec); end
        if (g_cnt != 3)   begin bad++; $display("FAIL andf_cnt got=%0d want=3", g_cnt); end
        if (g_lat != 5)   begin bad++; $display("FAIL andf_lat got=%0d want=5", g_lat); end
    endtask

    task automatic test_or_single();
        for (int i = 0; i < NV; i++) cfg_write(i, 5, 5);
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom_range(6, 60000));
        vm[17] = 16'd5;
        run_vec(1, 0, 0, 0, 0);
        total += 4;
        if (g_x !== 1'b1) begin bad++; $display("FAIL ors_x got=%b want=1", g_x); end
        if (g_dec != 17)  begin bad++; $display("FAIL ors_dec got=%0d want=17", g_dec); end
        if (g_cnt != 1)   begin bad++; $display("FAIL ors_cnt got=%0d want=1", g_cnt); end
        if (g_lat != 19)  begin bad++; $display("FAIL ors_lat got=%0d want=19", g_lat); end
    endtask

    task automatic test_empty_range();
        cfg_write(0, 9, 4);
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom_range(6, 60000));
        vm[0] = 16'd6;
        run_vec(1, 0, 0, 0, 0);
        total += 3;
        if (g_x !== 1'b0) begin bad++; $display("FAIL empty_x got=%b want=0", g_x); end
        if (g_dec != 34)  begin bad++; $display("FAIL empty_dec got=%0d want=34", g_dec); end
        if (g_cnt != 0)   begin bad++; $display("FAIL empty_cnt got=%0d want=0", g_cnt); end
    endtask

    task automatic test_same_cycle_cfg();
        do_reset();
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom);
        vm[2] = 16'd7;
        lo_m[2] = 16'd1;
        hi_m[2] = 16'd1;
        run_vec(0, 1, 2, 1, 1);
        total += 3;
        if (g_x !== 1'b0) begin bad++; $display("FAIL same_x got=%b want=0", g_x); end
        if (g_dec != 2)   begin bad++; $display("FAIL same_dec got=%0d want=2", g_dec); end
        if (g_cnt != 2)   begin bad++; $display("FAIL same_cnt got=%0d want=2", g_cnt); end
    endtask

    task automatic test_busy_write();
        do_reset();
        cfg_write(20, 0, 100);
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom);
        vm[20] = 16'd50;
        out_ready = 1'b0;
        fork
            run_vec(0, 0, 0, 0, 0);
            begin
                repeat (3) @(negedge clk);
                cfg_we = 1'b1; cfg_idx = 6'd20; cfg_lo = 16'd200; cfg_hi = 16'd300;
                @(negedge clk);
                cfg_we = 1'b0;
            end
        join
        total += 3;
        if (g_x !== 1'b1) begin bad++; $display("FAIL busy1_x got=%b want=1", g_x); end
        if (g_dec != 34)  begin bad++; $display("FAIL busy1_dec got=%0d want=34", g_dec); end
        if (g_cnt != 35)  begin bad++; $display("FAIL busy1_cnt got=%0d want=35", g_cnt); end
        // Write attempted while the result waits in DONE must also be dropped.
        cfg_we = 1'b1; cfg_idx = 6'd20; cfg_lo = 16'd200; cfg_hi = 16'd300;
        @(negedge clk);
        cfg_we = 1'b0;
        out_ready = 1'b1;
        run_vec(0, 0, 0, 0, 0);
        total += 2;
        if (g_x !== 1'b1) begin bad++; $display("FAIL busy2_x got=%b want=1", g_x); end
        if (g_dec != 34)  begin bad++; $display("FAIL busy2_dec got=%0d want=34", g_dec); end
    endtask

    task automatic test_random();
        int mode;
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) begin
                int lo;
                lo = $urandom_range(0, 1000);
                cfg_write($urandom_range(0, 63), lo, lo + $urandom_range(0, 3000) - 200);
            end
            for (int i = 0; i < NV; i++) vm[i] = VW'($urandom_range(0, 4000));
            mode = $urandom_range(0, 1);
            model(mode);
            run_vec(mode, 0, 0, 0, 0);
            total += 4;
            if (g_x !== e_x[0]) begin bad++; $display("FAIL rand%0d_x got=%b want=%0d", t, g_x, e_x); end
            if (g_dec != e_dec) begin bad++; $display("FAIL rand%0d_dec got=%0d want=%0d", t, g_dec, e_dec); end
            if (g_cnt != e_cnt) begin bad++; $display("FAIL rand%0d_cnt got=%0d want=%0d", t, g_cnt, e_cnt); end
            if (g_lat != e_lat) begin bad++; $display("FAIL rand%0d_lat got=%0d want=%0d", t, g_lat, e_lat); end
        end
    endtask

    task automatic test_hold_and_reset();
        logic hx;
        int hdec, hcnt;
        cfg_write(5, 0, 0);
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom_range(1, 60000));
        out_ready = 1'b0;
        run_vec(0, 0, 0, 0, 0);
        hx = x; hdec = int'(dec_idx); hcnt = int'(pass_cnt);
        total += 2;
        if (hdec != 5) begin bad++; $display("FAIL hold_dec got=%0d want=5", hdec); end
        if (hcnt != 5) begin bad++; $display("FAIL hold_cnt got=%0d want=5", hcnt); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || x !== hx || int'(dec_idx) != hdec || int'(pass_cnt) != hcnt || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_c%0d got v=%b x=%b d=%0d n=%0d r=%b want v=1 x=%b d=%0d n=%0d r=0",
                         c, out_valid, x, dec_idx, pass_cnt, in_ready, hx, hdec, hcnt);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        for (int i = 0; i < NV; i++) in_vars[i*VW +: VW] = VW'($urandom_range(1, 60000));
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        if (cfg_busy !== 1'b0)  begin bad++; $display("FAIL rst_cfg_busy got=%b want=0", cfg_busy); end
        @(negedge clk);
        rst = 1'b0;
        model_reset_ranges();
        for (int i = 0; i < NV; i++) vm[i] = VW'($urandom);
        run_vec(0, 0, 0, 0, 0);
        total += 3;
        if (g_x !== 1'b1) begin bad++; $display("FAIL rst_full_x got=%b want=1", g_x); end
        if (g_dec != 34)  begin bad++; $display("FAIL rst_full_dec got=%0d want=34", g_dec); end
        if (g_cnt != 35)  begin bad++; $display("FAIL rst_full_cnt got=%0d want=35", g_cnt); end
    endtask

    initial begin
        model_reset_ranges();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_and_fail();
        test_or_single();
        test_empty_range();
        test_same_cycle_cfg();
        test_busy_write();
        do_reset();
        test_random();
        test_hold_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/split_eval.md
# split_eval

Parametrised, sequential successor to the fixed-width split blocks. It accepts a packed vector of `N_VARS` unsigned variables and checks each one against a programmable inclusive range `[lo, hi]`, one variable per cycle. It combines the per-variable results as AND (all must pass) or OR (any may pass), exits early once the answer is decided, and returns the verdict `x` through a valid/ready handshake. Reset configuration is full-range on every variable, so the verdict is 1 for any input, which matches the constant-true behaviour of the earlier split blocks.

## Interface
- `N_VARS`, default 35: number of variables; must be ≥ 1.
- `VAR_W`, default 16: width of each variable slot. Narrower variables are zero-extended upstream.
- `IDX_W`, default max(1, $clog2(N_VARS)): index width.
- `CNT_W`, default $clog2(N_VARS+1): width of the pass counter.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: input vector and mode are valid.
- `in_ready`  out  1: block can accept a vector; high only in IDLE.
- `in_vars`  in  N_VARS*VAR_W: variable i occupies bits [i*VAR_W +: VAR_W].
- `in_mode`  in  1: 0 = AND, 1 = OR; sampled on accept.
- `cfg_we`  in  1: range write strobe.
- `cfg_idx`  in  IDX_W: variable to configure.
- `cfg_lo`, `cfg_hi`  in  VAR_W each: inclusive bounds.
- `cfg_busy`  out  1: high when state ≠ IDLE.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `x`  out  1: verdict.
- `dec_idx`  out  IDX_W: index of the variable that decided the verdict.
- `pass_cnt`  out  CNT_W: number of evaluated variables that passed.

## Operation
- States: IDLE, EVAL, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `in_vars` and `in_mode`, clear `idx` and `pass_cnt`, go to EVAL.
- EVAL:
  - Each cycle, compute pass = (lo[idx] ≤ v[idx]) && (v[idx] ≤ hi[idx]), both comparisons unsigned. lo > hi is an empty range and always fails.
  - `pass_cnt` += pass.
  - AND mode:
    - fail → x=0, `dec_idx`=idx, go to DONE.
    - pass at idx=N_VARS-1 → x=1, `dec_idx`=N_VARS-1, go to DONE.
  - OR mode:
    - pass → x=1, `dec_idx`=idx, go to DONE.
    - fail at idx=N_VARS-1 → x=0, `dec_idx`=N_VARS-1, go to DONE.
  - Otherwise idx++.
- DONE:
  - `out_valid`=1; `x`, `dec_idx` and `pass_cnt` are held stable.
  - On `out_ready`: go to IDLE.
  - The next input is not accepted in the same cycle; `in_ready` rises one cycle later.
- Configuration:
  - `cfg_we` takes effect only when the state is IDLE.
  - Writes while `cfg_busy`=1 are dropped silently.
  - `cfg_idx` ≥ N_VARS is ignored.
  - A write in the same cycle as an input accept takes effect before that vector is evaluated. The range registers are read starting in the next cycle.
- Reset:
  - lo[i]=0, hi[i]=all ones for every i.
  - State IDLE; `out_valid`=0, `x`=0, `dec_idx`=0, `pass_cnt`=0, `in_ready`=1 after reset deasserts, `cfg_busy`=0.
  - A reset during EVAL or DONE abandons the operation; the result is lost.

## Timing
- The accept edge is cycle 0; variable k is evaluated in cycle k+1.
- Decision at variable k → `out_valid` high from cycle k+2.
- Full scan → `out_valid` at cycle N_VARS+1.
- Minimum accept-to-accept spacing is k+3 cycles, with `out_ready` tied high.
- Outputs are registered; there are no combinational paths from inputs to outputs except `in_ready`, which is decoded from state.
- `out_valid` never drops without `out_ready`.

## Structure
- `split_pkg`: state enum {IDLE, EVAL, DONE}, mode constants MODE_AND=0 and MODE_OR=1, and the default-range constants.
- Sub-module `split_range_cmp`: combinational VAR_W unsigned inclusive-range check with inputs v, lo, hi and output pass. It is instanced once, on the muxed variable at `idx`.
- The top level holds the range register file (2·N_VARS·VAR_W flops), the captured vector, the FSM and the counters.

## Test plan
- Post-reset, N_VARS=35, VAR_W=16, AND, random vector, `out_ready`=1:
  - required: x=1, `dec_idx`=34, `pass_cnt`=35, `out_valid` at cycle 36.
- cfg var 3 = [10,20], AND, v3=25, all other vars in range:
  - required: x=0, `dec_idx`=3, `pass_cnt`=3, `out_valid` at cycle 5.
- All ranges [5,5], OR, only v17=5:
  - required: x=1, `dec_idx`=17, `pass_cnt`=1.
- cfg var 0 = lo 9, hi 4 (empty range), v0=6, OR, no other var passes:
  - required: x=0, `dec_idx`=34, `pass_cnt`=0.
- `cfg_we` asserted during EVAL with new bounds, then a second vector in IDLE:
  - required: the first result uses the old bounds and the dropped write leaves them unchanged.
- `out_ready` held low for 10 cycles in DONE, then `rst` pulsed mid-EVAL on the next vector:
  - required: outputs stable and `out_valid` held for all 10 cycles.
  - required after reset: `out_valid`=0, `in_ready`=1, ranges back to full.
